// File: rtl/mmio_responder_pkg.sv
// -----------------------------------------------------------------------------
// mmio_responder_pkg
// Shared constants for the MMIO responder: the I/O window tag, the register
// offsets inside the window, and the hex-to-seven-segment glyph table.
// Segment bytes are {a,b,c,d,e,f,g,dp}, active-low, with dp always off.
// -----------------------------------------------------------------------------
package mmio_responder_pkg;

  localparam logic [23:0] IO_TAG = 24'hFFFFFC;

  localparam logic [7:0] IO_LED = 8'h00;
  localparam logic [7:0] IO_SW  = 8'h04;
  localparam logic [7:0] IO_BTN = 8'h08;
  localparam logic [7:0] IO_SEG = 8'h0C;
  localparam logic [7:0] IO_CNT = 8'h10;

  // Glyphs 0..F, active-low segments, dp (bit 0) held high.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/mmio_responder_seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Multiplexed scan of an 8-digit seven-segment display.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   value   : 32-bit value, digit i shows nibble value[4i+3:4i]
//   seg_an  : digit enables, active-low one-hot (~(1 << idx))
//   seg_out : segments {a,b,c,d,e,f,g,dp}, active-low
// The digit index advances once every SCAN_DIV cycles and wraps 7 -> 0.
// Outputs are decoded combinationally from the index so they follow reset
// immediately.
// -----------------------------------------------------------------------------
module seg_scan
  import mmio_responder_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);

  logic [DIVW-1:0] r_div;
  logic [2:0]      r_idx;
  logic [3:0]      w_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 3'd1;   // natural 3-bit wrap gives 7 -> 0
    end else begin
      r_div <= r_div + DIVW'(1);
    end
  end

  assign w_nib   = value[{r_idx, 2'b00} +: 4];
  assign seg_an  = ~(8'd1 << r_idx);
  assign seg_out = hex_to_seg(w_nib);

endmodule

// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
// Memory-mapped I/O responder for the 0xFFFFFCxx window of the RISC-V core.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   ioRead, ioWrite : load / store strobes for this cycle
//   addr, wdata     : byte address and store data
//   rdata           : load data, combinational (0 when no hitting load)
//   sw_raw, btn_raw : asynchronous board switches / button
//   led             : LED register
//   seg_an, seg_out : seven-segment digit enables and segments (active-low)
// Register map (offset = addr[7:0], addr[1:0] ignored):
//   0x00 LED RW, 0x04 SW RO, 0x08 BTN RO {pressed, btn_stable} (read clears
//   pressed), 0x0C SEG RW, 0x10 CNT cycle counter (any write clears).
// -----------------------------------------------------------------------------
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SCAN_DIV        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioRead,
  input  logic        ioWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] sw_raw,
  input  logic        btn_raw,
  output logic [15:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [15:0]    r_sw_meta, r_sw_sync;
  logic           r_btn_meta, r_btn_sync;
  logic [DBW-1:0] r_db_cnt;
  logic           r_btn_stable;
  logic           r_pressed;
  logic [15:0]    r_led;
  logic [31:0]    r_seg;
  logic [31:0]    r_cnt;

  logic           w_hit, w_rd, w_wr;
  logic [7:0]     w_off;
  logic           w_db_accept, w_rise;
  logic           w_unused_addr;

  assign w_hit = (addr[31:8] == IO_TAG);
  assign w_off = {addr[7:2], 2'b00};
  assign w_rd  = ioRead  & w_hit;
  assign w_wr  = ioWrite & w_hit;
  assign w_unused_addr = &{1'b0, addr[1:0]};

  // The debouncer accepts the new level on the cycle its counter has run the
  // full window; a rising acceptance is what arms the sticky press flag.
  assign w_db_accept = (r_btn_sync != r_btn_stable) && (r_db_cnt == DB_LAST);
  assign w_rise      = w_db_accept & r_btn_sync;

  // Synchronizers and debouncer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta    <= '0;
      r_sw_sync    <= '0;
      r_btn_meta   <= 1'b0;
      r_btn_sync   <= 1'b0;
      r_db_cnt     <= '0;
      r_btn_stable <= 1'b0;
    end else begin
      r_sw_meta  <= sw_raw;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= btn_raw;
      r_btn_sync <= r_btn_meta;
      if (r_btn_sync == r_btn_stable) begin
        r_db_cnt <= '0;
      end else if (w_db_accept) begin
        r_btn_stable <= r_btn_sync;
        r_db_cnt     <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end
  end

  // Sticky press flag: a set in the same cycle as a clearing read wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pressed <= 1'b0;
    end else if (w_rise) begin
      r_pressed <= 1'b1;
    end else if (w_rd && (w_off == IO_BTN)) begin
      r_pressed <= 1'b0;
    end
  end

  // Writable registers and the free-running cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
      r_seg <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr && (w_off == IO_LED)) r_led <= wdata[15:0];
      if (w_wr && (w_off == IO_SEG)) r_seg <= wdata;
      if (w_wr && (w_off == IO_CNT)) r_cnt <= '0;
      else                           r_cnt <= r_cnt + 32'd1;
    end
  end

  // Read mux shows pre-edge state, so a simultaneous write is not visible yet.
  always_comb begin
    rdata = '0;
    if (w_rd) begin
      case (w_off)
        IO_LED:  rdata = {16'h0, r_led};
        IO_SW:   rdata = {16'h0, r_sw_sync};
        IO_BTN:  rdata = {30'h0, r_pressed, r_btn_stable};
        IO_SEG:  rdata = r_seg;
        IO_CNT:  rdata = r_cnt;
        default: rdata = '0;
      endcase
    end
  end

  assign led = r_led;

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (r_seg),
    .seg_an  (seg_an),
    .seg_out (seg_out)
  );

endmodule

// File: tb/tb_mmio_responder.sv
// -----------------------------------------------------------------------------
// tb_mmio_responder
// Directed bench for mmio_responder with DEBOUNCE_CYCLES = 20, SCAN_DIV = 4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mmio_responder;

  localparam logic [31:0] A_LED = 32'hFFFFFC00;
  localparam logic [31:0] A_SW  = 32'hFFFFFC04;
  localparam logic [31:0] A_BTN = 32'hFFFFFC08;
  localparam logic [31:0] A_SEG = 32'hFFFFFC0C;
  localparam logic [31:0] A_CNT = 32'hFFFFFC10;

  logic        clk;
  logic        rst_n;
  logic        ioRead, ioWrite;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] sw_raw;
  logic        btn_raw;
  logic [15:0] led;
  logic [7:0]  seg_an, seg_out;

  int n_checks = 0;
  int n_errors = 0;

  mmio_responder #(
    .DEBOUNCE_CYCLES (20),
    .SCAN_DIV        (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ioRead  (ioRead),
    .ioWrite (ioWrite),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .sw_raw  (sw_raw),
    .btn_raw (btn_raw),
    .led     (led),
    .seg_an  (seg_an),
    .seg_out (seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // One-cycle load: drive on falling edge, check combinational data, release
  // the strobe just after the rising edge that commits any side effect.
  task automatic io_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    ioRead = 1'b1;
    addr   = a;
    #1 chk(tag, rdata, exp);
    @(posedge clk);
    #1 ioRead = 1'b0;
  endtask

  task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ioWrite = 1'b1;
    addr    = a;
    wdata   = d;
    @(posedge clk);
    #1 ioWrite = 1'b0;
    $display("wr   %08h <= %08h", a, d);
  endtask

  // Glyphs expected for SEG = 0x12345678 at digit index 0..7 (nibbles 8..1).
  logic [7:0] exp_glyph [8] = '{8'h01, 8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F};

  initial begin
    logic [31:0] c_a, c_b;
    logic [7:0]  exp_an;
    bit          found;

    rst_n = 1'b0; ioRead = 1'b0; ioWrite = 1'b0;
    addr = '0; wdata = '0; sw_raw = '0; btn_raw = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    ioRead = 1'b1; addr = A_LED;
    #1;
    chk("rst_led",     {16'h0, led},     32'h0);
    chk("rst_seg_an",  {24'h0, seg_an},  32'hFE);
    chk("rst_seg_out", {24'h0, seg_out}, 32'h03);
    chk("rst_rdata",   rdata,            32'h0);
    ioRead = 1'b0;
    rst_n = 1'b1;

    // LED register, decode miss, ignored low address bits, unmapped offset
    io_wr(A_LED, 32'h0000A5A5);
    @(negedge clk); chk("led_after_wr", {16'h0, led}, 32'hA5A5);
    io_rd(A_LED, 32'h0000A5A5, "led_rd");
    io_wr(32'h00000000, 32'h0000FFFF);
    @(negedge clk); chk("led_miss_wr", {16'h0, led}, 32'hA5A5);
    io_rd(32'h00000000, 32'h0, "miss_rd");
    io_rd(32'hFFFFFC03, 32'h0000A5A5, "led_rd_lowbits");
    io_rd(32'hFFFFFC14, 32'h0, "unmapped_rd");

    // Switches: two cycles of synchronizer latency
    @(negedge clk);
    sw_raw = 16'h1234; ioRead = 1'b1; addr = A_SW;
    #1 chk("sw_cyc1", rdata, 32'h0);
    @(negedge clk); #1 chk("sw_cyc2", rdata, 32'h0);
    @(negedge clk); #1 chk("sw_cyc3", rdata, 32'h1234);
    @(posedge clk); #1 ioRead = 1'b0;

    // Button glitch of 10 cycles is rejected
    @(negedge clk); btn_raw = 1'b1;
    repeat (10) @(negedge clk);
    btn_raw = 1'b0;
    repeat (30) @(negedge clk);
    io_rd(A_BTN, 32'h0, "btn_glitch");

    // Held press: still 0 after 21 edges, 0x3 after the 22nd. The read is
    // held across that 22nd edge so the press set must beat the read clear.
    @(negedge clk); btn_raw = 1'b1;
    repeat (21) @(negedge clk);
    ioRead = 1'b1; addr = A_BTN;
    #1 chk("btn_edge21", rdata, 32'h0);
    @(posedge clk); #1 ioRead = 1'b0;
    io_rd(A_BTN, 32'h3, "btn_held");
    io_rd(A_BTN, 32'h1, "btn_held_clr");
    btn_raw = 1'b0;
    repeat (30) @(negedge clk);
    io_rd(A_BTN, 32'h0, "btn_released");

    // Press and release without reading: sticky flag survives
    btn_raw = 1'b1;
    repeat (30) @(negedge clk);
    btn_raw = 1'b0;
    repeat (30) @(negedge clk);
    io_rd(A_BTN, 32'h2, "btn_sticky");
    io_rd(A_BTN, 32'h0, "btn_sticky_clr");

    // Counter: consecutive reads differ by one
    @(negedge clk);
    ioRead = 1'b1; addr = A_CNT;
    #1 c_a = rdata;
    @(negedge clk);
    #1 c_b = rdata;
    chk("cnt_step", c_b - c_a, 32'd1);
    @(posedge clk); #1 ioRead = 1'b0;

    // Counter: write clears, then resumes
    io_wr(A_CNT, 32'hDEADBEEF);
    io_rd(A_CNT, 32'd0, "cnt_clr0");
    io_rd(A_CNT, 32'd1, "cnt_clr1");

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.r_cnt = 32'hFFFFFFFF;
    #1 release dut.r_cnt;
    ioRead = 1'b1; addr = A_CNT;
    #1 chk("cnt_max", rdata, 32'hFFFFFFFF);
    @(posedge clk);
    #1 chk("cnt_wrap", rdata, 32'h0);
    ioRead = 1'b0;

    // Simultaneous read and write: read shows the old value
    @(negedge clk);
    ioRead = 1'b1; ioWrite = 1'b1; addr = A_LED; wdata = 32'h0000005A;
    #1 chk("rw_pre", rdata, 32'h0000A5A5);
    @(posedge clk); #1 ioRead = 1'b0; ioWrite = 1'b0;
    io_rd(A_LED, 32'h0000005A, "rw_post");

    // Seven-segment scan of 0x12345678
    io_wr(A_SEG, 32'h12345678);
    io_rd(A_SEG, 32'h12345678, "seg_rd");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (seg_an == 8'h7F) found = 1'b1;
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge clk);
        if (seg_an == 8'hFE) found = 1'b1;
      end
    end
    if (!found) begin
      chk("seg_sync_timeout", 32'h0, 32'h1);
    end else begin
      for (int k = 0; k < 8; k++) begin
        exp_an = ~(8'd1 << k);
        chk($sformatf("seg_out_idx%0d", k), {24'h0, seg_out}, {24'h0, exp_glyph[k]});
        for (int j = 0; j < 4; j++) begin
          if (j != 0) @(negedge clk);
          #1 chk($sformatf("seg_an_idx%0d_c%0d", k, j), {24'h0, seg_an}, {24'h0, exp_an});
        end
        @(negedge clk);
      end
      chk("seg_an_wrap", {24'h0, seg_an}, 32'hFE);
    end

    // Asynchronous reset mid-scan with LED nonzero
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_led",     {16'h0, led},     32'h0);
    chk("arst_seg_an",  {24'h0, seg_an},  32'hFE);
    chk("arst_seg_out", {24'h0, seg_out}, 32'h03);
    ioRead = 1'b1; addr = A_CNT;
    #1 chk("arst_cnt", rdata, 32'h0);
    addr = A_SEG;
    #1 chk("arst_seg", rdata, 32'h0);
    ioRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder for the single-cycle RISC-V core, sitting at the far end of the controller's `ioRead`/`ioWrite` strobes. It decodes the 0xFFFFFCxx I/O window and serves loads and stores to the board peripherals: LEDs, switches, a debounced button with a sticky press flag, a seven-segment display value, and a free-running cycle counter. It returns read data combinationally so the core can write back in the same cycle. All state changes occur on the clock edge.

## Interface
- `DEBOUNCE_CYCLES`, 20, cycles a synchronized button level must hold before it is accepted (board build: 1_000_000)
- `SCAN_DIV`, 4, clock cycles per seven-segment digit slot (board build: 100_000)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `ioRead` in 1: load to the I/O window this cycle
- `ioWrite` in 1: store to the I/O window this cycle
- `addr` in 32: byte address (ALU result)
- `wdata` in 32: store data
- `rdata` out 32: load data, combinational
- `sw_raw` in 16: board switches, asynchronous
- `btn_raw` in 1: board button, asynchronous, active-high
- `led` out 16: LED register
- `seg_an` out 8: digit enables, active-low one-hot
- `seg_out` out 8: segments {a,b,c,d,e,f,g,dp}, active-low

## Operation
- Hit: `addr[31:8] == 24'hFFFFFC`. Strobes without a hit are ignored and `rdata` = 0.
- Register map, with `addr[7:0]` as the offset:
  - 0x00 LED: RW. `led` = `wdata[15:0]`. Reads return `{16'h0, led}`.
  - 0x04 SW: RO. Reads return `{16'h0, sw_sync}`.
  - 0x08 BTN: RO. Reads return `{30'h0, pressed, btn_stable}`. A read clears `pressed` at the clock edge.
  - 0x0C SEG: RW. Full 32-bit value, shown as 8 hex digits.
  - 0x10 CNT: reads return the 32-bit cycle counter. Any write clears it.
  - Other offsets: read 0, writes ignored.
  - `addr[1:0]` is ignored.
- Switches: two-flop synchronizer, giving `sw_sync`.
- Button: two-flop synchronizer, then the debouncer.
  - When the synchronized level equals `btn_stable`, the debounce counter is 0.
  - Otherwise the counter increments each cycle. When it reaches `DEBOUNCE_CYCLES-1`, `btn_stable` takes the new level and the counter returns to 0.
  - A 0→1 transition of `btn_stable` sets `pressed`.
  - If a set and a clear-by-read happen in the same cycle, the set wins.
- Counter: increments every cycle and wraps at 2^32−1 → 0. A write has priority: the counter is 0 the next cycle, then resumes counting.
- If `ioRead` and `ioWrite` are high together, the write takes effect and `rdata` shows the pre-write value.
- Seven-segment display:
  - A digit index 0..7 advances every `SCAN_DIV` cycles and wraps 7→0.
  - `seg_an` = ~(1<<idx).
  - `seg_out` encodes SEG nibble [4·idx+3 : 4·idx] as hex 0–F. `dp` is always off (1).

## Timing
- `rdata` is valid in the same cycle as `ioRead` and `addr`, with no wait states.
- Writes and read side effects take effect at the rising edge, and are visible to a read in the next cycle.
- Switch latency: 2 cycles from `sw_raw` to SW reads.
- Button latency: 2 + `DEBOUNCE_CYCLES` cycles from `btn_raw` change to `btn_stable`. `pressed` sets in the same edge as `btn_stable`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles is rejected.
- Reset values: `led` 0, SEG 0, counter 0, `pressed` 0, `btn_stable` 0, synchronizers 0, digit index 0, `seg_an` 8'hFE, `seg_out` 8'h03 (glyph '0').
- Reset asserted mid-operation returns every register to these values immediately, independent of the clock.

## Structure
- Shared package/header:
  - Window tag 24'hFFFFFC.
  - Offsets: `IO_LED` 0x00, `IO_SW` 0x04, `IO_BTN` 0x08, `IO_SEG` 0x0C, `IO_CNT` 0x10.
  - The hex-to-segment constant table.
- Sub-module `seg_scan` contains the digit index counter, the `SCAN_DIV` prescaler and the segment decode. Its inputs are `clk`, `rst_n` and the 32-bit value; its outputs are `seg_an` and `seg_out`.
- Everything else lives in `mmio_responder`.

## Test plan
- Store 0x0000A5A5 to 0xFFFFFC00 → `led` = 16'hA5A5 after the edge. A load from 0xFFFFFC00 returns 0x0000A5A5. A store to 0x00000000 leaves `led` unchanged.
- Set `sw_raw` = 16'h1234 → a load from 0xFFFFFC04 returns 0x1234 on the 3rd cycle and 0 before that.
- Button, with `DEBOUNCE_CYCLES` = 20:
  - A 10-cycle pulse leaves BTN reading 0.
  - A held press reads 0x3 after 22 cycles.
  - After release and settling, the first read returns 0x2 and the next read returns 0x0.
- Store 0x12345678 to 0xFFFFFC0C with `SCAN_DIV` = 4:
  - `seg_an` cycles FE, FD, …, 7F every 4 cycles.
  - At idx 0, `seg_out` is the glyph for '8'; at idx 7, the glyph for '1'.
- Counter:
  - Read 0xFFFFFC10 on two consecutive cycles → values differ by 1.
  - A store to 0xFFFFFC10 gives a read of 0 the next cycle and 1 the cycle after.
  - Force-load 0xFFFFFFFF, and the counter wraps to 0.
- Assert `rst_n` = 0 asynchronously mid-scan with `led` nonzero → all outputs return to their reset values before the next clock edge.
